processor_forwarding_unit: RTL and testbench
============================================

# processor_forwarding_unit

Operand forwarding unit for the five-stage pipelined ARM64 core, sitting between Instruction Decode and the ID/EX pipeline register. It selects each of the two source-operand values from one of three places: the register-file reads, the in-flight Execute result, or the in-flight Memory-Access result. The selected values are presented combinationally and also captured into registered copies for the Execute stage.

## Interface
Parameters:
- none (data width fixed at 64, register index width fixed at 5).

Ports:
- `clk`  in  1  pipeline clock; one clock domain, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ID_instruction`  in  32  decode-stage instruction; Rn=[9:5], Rm=[20:16], Rd=[4:0].
- `Reg2Loc`  in  1  selects the Db source register: 1 = Rm, 0 = Rd.
- `Da`  in  64  register-file read port 0 value (for Rn).
- `Db`  in  64  register-file read port 1 value (for Rm or Rd).
- `EX_instruction`  in  32  execute-stage instruction; EX_Rd=[4:0].
- `EX_data`  in  64  execute-stage result.
- `EX_MemWrite`, `EX_MemRead`, `EX_RegWrite`  in  1 each  execute-stage control bits.
- `MA_Rd`  in  5  memory-access-stage destination register.
- `MA_data`  in  64  memory-access-stage result (load, MOV or ALU).
- `MA_MemWrite`, `MA_MemRead`, `MA_RegWrite`  in  1 each  memory-access-stage control bits.
- `Da_forwarded`  out  64  combinational forwarded value for Rn.
- `Db_forwarded`  out  64  combinational forwarded value for Rm/Rd.
- `Da_ex`  out  64  registered copy of `Da_forwarded`.
- `Db_ex`  out  64  registered copy of `Db_forwarded`.

## Operation
- Each stage's control triple is classified as {MemWrite, MemRead, RegWrite}.
  - Branch = 000.
  - Store = 100.
  - Load = 011.
- EX_valid = not Branch, not Store, not Load, and EX_Rd≠31.
  - An EX load is never forwarded, because its data is not ready in EX. The hazard unit stalls for it; that is outside this block.
- MA_valid = not Branch, not Store, and MA_Rd≠31.
  - A load in MA is forwardable.
- All control combinations not listed above count as valid.
- Da select:
  - EX hit = (EX_Rd==Rn) and EX_valid.
  - MA hit = (MA_Rd==Rn) and MA_valid.
- Db select:
  - The compare register is Rm if Reg2Loc=1, otherwise Rd.
  - Hit terms are formed exactly as for Da.
- Output mux per operand, keyed by {EX hit, MA hit}:
  - 00 → register-file value.
  - 01 → MA_data.
  - 10 or 11 → EX_data. EX has priority over MA.
- X31 (XZR) is never forwarded. Da/Db pass through untouched.

## Timing
- `Da_forwarded`/`Db_forwarded` are purely combinational from the inputs, with zero-cycle latency.
- `Da_ex`/`Db_ex` load the combinational values on every rising `clk`, giving 1-cycle latency. There is no enable; stall/flush is handled by the surrounding pipeline.
- `rst_n` low asynchronously clears `Da_ex` and `Db_ex` to 64'h0.
  - Deassertion takes effect at the next rising edge.
  - Reset mid-operation discards the pending capture.
- The combinational outputs are unaffected by reset.
- Simultaneous EX and MA hits on the same register select EX_data.
- Da and Db resolve independently; both may hit the same stage in the same cycle.

## Structure
- Shared package constants:
  - `XZR` = 5'd31.
  - Field bit positions for Rn/Rm/Rd.
  - Data width 64.
- Sub-modules:
  - `isEqual5`: 5-bit equality comparator, instantiated 6×.
  - `mux2x1_base`: 1-bit 2:1 mux for the Reg2Loc choice between the Rm and Rd compares.
  - `mux4x1`: parameterised-width 4:1 mux with an array input and a 2-bit port, 64-bit here.
- One always_ff block holds the registered copies.

## Test plan
- Register file pass-through:
  - Set Rn=Rm=Rd=0, EX_Rd=MA_Rd=31, Da=DEAD, Db=F00D, random control bits.
  - Required: Da_forwarded=DEAD and Db_forwarded=F00D in every case.
- EX priority:
  - Set Rn=0, EX_Rd=MA_Rd=0, EX ctrl=001, MA ctrl=001, EX_data=BEEF, MA_data=CAFE.
  - Required: Da_forwarded=BEEF.
- MA forwarding past an EX load/store/branch:
  - Set EX ctrl ∈ {011,100,000}, MA ctrl=011.
  - Required: Da_forwarded=CAFE.
- Reg2Loc selection:
  - Set Rd=10, Rm=0, Reg2Loc=0, EX_Rd=MA_Rd=0, Db=AAAAF00D.
    - Required: Db_forwarded=AAAAF00D.
  - Then set Rm=10, EX_Rd=10, Reg2Loc=1, EX ctrl=001.
    - Required: Db_forwarded=BEEF.
- MA store/branch ignored:
  - Set MA ctrl=100 or 000, EX_Rd≠Rn, MA_Rd=Rn.
  - Required: the register-file value is output.
- Register and reset:
  - Apply rst_n=0 asynchronously.
    - Required: Da_ex=Db_ex=0 immediately.
  - Release reset and apply an EX hit.
    - Required: Da_ex=BEEF one edge after.

Source files
------------

// File: rtl/processor_forwarding_unit_pkg.sv
// Shared constants and helpers for the operand forwarding unit: field
// positions, widths and the control-triple classification.
package processor_forwarding_unit_pkg;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;

    localparam logic [REG_W-1:0] XZR = 5'd31;

    localparam int RN_LSB = 5;
    localparam int RN_MSB = 9;
    localparam int RM_LSB = 16;
    localparam int RM_MSB = 20;
    localparam int RD_LSB = 0;
    localparam int RD_MSB = 4;

    // Control triple ordered {MemWrite, MemRead, RegWrite}
    typedef enum logic [2:0] {
        CTRL_BRANCH = 3'b000,
        CTRL_STORE  = 3'b100,
        CTRL_LOAD   = 3'b011
    } ctrl_class_t;

    // An EX load has no data yet, so it is excluded along with stores/branches
    function automatic logic ex_forwardable(input logic [2:0] ctrl, input logic [REG_W-1:0] rd);
        return (ctrl != CTRL_BRANCH) && (ctrl != CTRL_STORE) &&
               (ctrl != CTRL_LOAD) && (rd != XZR);
    endfunction

    function automatic logic ma_forwardable(input logic [2:0] ctrl, input logic [REG_W-1:0] rd);
        return (ctrl != CTRL_BRANCH) && (ctrl != CTRL_STORE) && (rd != XZR);
    endfunction

endpackage

// File: rtl/processor_forwarding_unit_if.sv
// Decode/EX/MA signal bundle seen by the forwarding unit; the slave side is
// the unit itself, the master side is the surrounding pipeline.
interface processor_forwarding_unit_if;
    import processor_forwarding_unit_pkg::*;

    logic [31:0]         ID_instruction;
    logic                Reg2Loc;
    logic [DATA_W-1:0]   Da;
    logic [DATA_W-1:0]   Db;
    logic [31:0]         EX_instruction;
    logic [DATA_W-1:0]   EX_data;
    logic                EX_MemWrite;
    logic                EX_MemRead;
    logic                EX_RegWrite;
    logic [REG_W-1:0]    MA_Rd;
    logic [DATA_W-1:0]   MA_data;
    logic                MA_MemWrite;
    logic                MA_MemRead;
    logic                MA_RegWrite;
    logic [DATA_W-1:0]   Da_forwarded;
    logic [DATA_W-1:0]   Db_forwarded;
    logic [DATA_W-1:0]   Da_ex;
    logic [DATA_W-1:0]   Db_ex;

    modport master (
        output ID_instruction, Reg2Loc, Da, Db,
        output EX_instruction, EX_data, EX_MemWrite, EX_MemRead, EX_RegWrite,
        output MA_Rd, MA_data, MA_MemWrite, MA_MemRead, MA_RegWrite,
        input  Da_forwarded, Db_forwarded, Da_ex, Db_ex
    );

    modport slave (
        input  ID_instruction, Reg2Loc, Da, Db,
        input  EX_instruction, EX_data, EX_MemWrite, EX_MemRead, EX_RegWrite,
        input  MA_Rd, MA_data, MA_MemWrite, MA_MemRead, MA_RegWrite,
        output Da_forwarded, Db_forwarded, Da_ex, Db_ex
    );

endinterface

// File: rtl/processor_forwarding_unit_prims.sv
// Small datapath primitives used by the forwarding unit: a 5-bit equality
// comparator, a 1-bit 2:1 mux and a parameterised 4:1 mux.
module isEqual5 (
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic       eq
);
    assign eq = (a == b);
endmodule

module mux2x1_base (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    assign y = sel ? b : a;
endmodule

module mux4x1 #(
    parameter int W = 64
) (
    input  logic [W-1:0] in [4],
    input  logic [1:0]   sel,
    output logic [W-1:0] out
);
    assign out = in[sel];
endmodule

// File: rtl/processor_forwarding_unit.sv
// Operand forwarding between ID and ID/EX: picks each source operand from the
// register file, the EX result or the MA result, and registers the choice.
module processor_forwarding_unit
    import processor_forwarding_unit_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    processor_forwarding_unit_if.slave    bus
);

    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rm;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] ex_rd;
    logic             ex_valid;
    logic             ma_valid;

    assign rn    = bus.ID_instruction[RN_MSB:RN_LSB];
    assign rm    = bus.ID_instruction[RM_MSB:RM_LSB];
    assign rd    = bus.ID_instruction[RD_MSB:RD_LSB];
    assign ex_rd = bus.EX_instruction[RD_MSB:RD_LSB];

    assign ex_valid = ex_forwardable({bus.EX_MemWrite, bus.EX_MemRead, bus.EX_RegWrite}, ex_rd);
    assign ma_valid = ma_forwardable({bus.MA_MemWrite, bus.MA_MemRead, bus.MA_RegWrite}, bus.MA_Rd);

    // Only the register fields of the instruction words matter here
    logic unused_bits;
    assign unused_bits = ^{bus.ID_instruction[31:21], bus.ID_instruction[15:10],
                           bus.EX_instruction[31:5]};

    logic rn_ex_eq, rn_ma_eq, rm_ex_eq, rm_ma_eq, rd_ex_eq, rd_ma_eq;

    isEqual5 u_rn_ex (.a(rn), .b(ex_rd),      .eq(rn_ex_eq));
    isEqual5 u_rn_ma (.a(rn), .b(bus.MA_Rd),  .eq(rn_ma_eq));
    isEqual5 u_rm_ex (.a(rm), .b(ex_rd),      .eq(rm_ex_eq));
    isEqual5 u_rm_ma (.a(rm), .b(bus.MA_Rd),  .eq(rm_ma_eq));
    isEqual5 u_rd_ex (.a(rd), .b(ex_rd),      .eq(rd_ex_eq));
    isEqual5 u_rd_ma (.a(rd), .b(bus.MA_Rd),  .eq(rd_ma_eq));

    logic b_ex_eq, b_ma_eq;

    mux2x1_base u_b_ex_sel (.a(rd_ex_eq), .b(rm_ex_eq), .sel(bus.Reg2Loc), .y(b_ex_eq));
    mux2x1_base u_b_ma_sel (.a(rd_ma_eq), .b(rm_ma_eq), .sel(bus.Reg2Loc), .y(b_ma_eq));

    logic [1:0] a_sel;
    logic [1:0] b_sel;

    assign a_sel = {rn_ex_eq & ex_valid, rn_ma_eq & ma_valid};
    assign b_sel = {b_ex_eq  & ex_valid, b_ma_eq  & ma_valid};

    // Index order {regfile, MA, EX, EX} gives EX priority on a double hit
    logic [DATA_W-1:0] a_sources [4];
    logic [DATA_W-1:0] b_sources [4];

    assign a_sources[0] = bus.Da;
    assign a_sources[1] = bus.MA_data;
    assign a_sources[2] = bus.EX_data;
    assign a_sources[3] = bus.EX_data;

    assign b_sources[0] = bus.Db;
    assign b_sources[1] = bus.MA_data;
    assign b_sources[2] = bus.EX_data;
    assign b_sources[3] = bus.EX_data;

    logic [DATA_W-1:0] da_fwd;
    logic [DATA_W-1:0] db_fwd;

    mux4x1 #(.W(DATA_W)) u_a_mux (.in(a_sources), .sel(a_sel), .out(da_fwd));
    mux4x1 #(.W(DATA_W)) u_b_mux (.in(b_sources), .sel(b_sel), .out(db_fwd));

    assign bus.Da_forwarded = da_fwd;
    assign bus.Db_forwarded = db_fwd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.Da_ex <= '0;
            bus.Db_ex <= '0;
        end else begin
            bus.Da_ex <= da_fwd;
            bus.Db_ex <= db_fwd;
        end
    end

endmodule

// File: tb/tb_processor_forwarding_unit.sv
// Directed-vector bench for processor_forwarding_unit: forwarding selection,
// Reg2Loc choice, XZR handling, registered copies and asynchronous reset.
module tb_processor_forwarding_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    processor_forwarding_unit_if bus ();

    processor_forwarding_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] id_word(input logic [4:0] rn, input logic [4:0] rm,
                                            input logic [4:0] rd);
        return {11'b0, rm, 6'b0, rn, rd};
    endfunction

    task automatic set_ex(input logic [4:0] rd, input logic [2:0] ctrl);
        bus.EX_instruction = {27'h0, rd};
        {bus.EX_MemWrite, bus.EX_MemRead, bus.EX_RegWrite} = ctrl;
    endtask

    task automatic set_ma(input logic [4:0] rd, input logic [2:0] ctrl);
        bus.MA_Rd = rd;
        {bus.MA_MemWrite, bus.MA_MemRead, bus.MA_RegWrite} = ctrl;
    endtask

    task automatic test_reset();
        rst_n          = 1'b1;
        bus.ID_instruction = id_word(5'd0, 5'd0, 5'd0);
        bus.Reg2Loc    = 1'b1;
        bus.Da         = 64'hDEAD;
        bus.Db         = 64'hF00D;
        bus.EX_data    = 64'hBEEF;
        bus.MA_data    = 64'hCAFE;
        set_ex(5'd31, 3'b001);
        set_ma(5'd31, 3'b001);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.Da_ex !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_da_ex got %h want %h", bus.Da_ex, 64'h0);
        end
        checks++;
        if (bus.Db_ex !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_db_ex got %h want %h", bus.Db_ex, 64'h0);
        end
        checks++;
        if (bus.Da_forwarded !== 64'hDEAD) begin
            errors++;
            $display("[TB] FAIL reset_comb_da got %h want %h", bus.Da_forwarded, 64'hDEAD);
        end
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 6; i++) begin
            bus.ID_instruction = id_word(5'd0, 5'd0, 5'd0);
            bus.Reg2Loc = 1'($urandom_range(0, 1));
            bus.Da = 64'hDEAD;
            bus.Db = 64'hF00D;
            set_ex(5'd31, 3'($urandom_range(0, 7)));
            set_ma(5'd31, 3'($urandom_range(0, 7)));
            #1;
            checks++;
            if (bus.Da_forwarded !== 64'hDEAD) begin
                errors++;
                $display("[TB] FAIL passthrough_da[%0d] got %h want %h", i, bus.Da_forwarded, 64'hDEAD);
            end
            checks++;
            if (bus.Db_forwarded !== 64'hF00D) begin
                errors++;
                $display("[TB] FAIL passthrough_db[%0d] got %h want %h", i, bus.Db_forwarded, 64'hF00D);
            end
        end
    endtask

    task automatic test_ex_priority();
        bus.ID_instruction = id_word(5'd0, 5'd0, 5'd7);
        bus.Reg2Loc = 1'b1;
        set_ex(5'd0, 3'b001);
        set_ma(5'd0, 3'b001);
        #1;
        checks++;
        if (bus.Da_forwarded !== 64'hBEEF) begin
            errors++;
            $display("[TB] FAIL ex_priority_da got %h want %h", bus.Da_forwarded, 64'hBEEF);
        end
        checks++;
        if (bus.Db_forwarded !== 64'hBEEF) begin
            errors++;
            $display("[TB] FAIL ex_priority_db got %h want %h", bus.Db_forwarded, 64'hBEEF);
        end
        // EX hit alone while MA points elsewhere
        set_ma(5'd3, 3'b001);
        #1;
        checks++;
        if (bus.Da_forwarded !== 64'hBEEF) begin
            errors++;
            $display("[TB] FAIL ex_only_da got %h want %h", bus.Da_forwarded, 64'hBEEF);
        end
    endtask

    task automatic test_ma_past_ex();
        logic [2:0] ex_ctrls [3];
        ex_ctrls[0] = 3'b011;
        ex_ctrls[1] = 3'b100;
        ex_ctrls[2] = 3'b000;
        bus.ID_instruction = id_word(5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            set_ex(5'd0, ex_ctrls[i]);
            set_ma(5'd0, 3'b011);
            #1;
            checks++;
            if (bus.Da_forwarded !== 64'hCAFE) begin
                errors++;
                $display("[TB] FAIL ma_past_ex[%b] got %h want %h", ex_ctrls[i], bus.Da_forwarded, 64'hCAFE);
            end
        end
    endtask

    task automatic test_reg2loc();
        bus.ID_instruction = id_word(5'd0, 5'd0, 5'd10);
        bus.Reg2Loc = 1'b0;
        bus.Db = 64'hAAAAF00D;
        set_ex(5'd0, 3'b001);
        set_ma(5'd0, 3'b001);
        #1;
        checks++;
        if (bus.Db_forwarded !== 64'hAAAAF00D) begin
            errors++;
            $display("[TB] FAIL reg2loc_rd got %h want %h", bus.Db_forwarded, 64'hAAAAF00D);
        end
        bus.ID_instruction = id_word(5'd0, 5'd10, 5'd10);
        bus.Reg2Loc = 1'b1;
        set_ex(5'd10, 3'b001);
        #1;
        checks++;
        if (bus.Db_forwarded !== 64'hBEEF) begin
            errors++;
            $display("[TB] FAIL reg2loc_rm got %h want %h", bus.Db_forwarded, 64'hBEEF);
        end
        // Rd path selected and only MA matches Rd
        bus.ID_instruction = id_word(5'd1, 5'd2, 5'd12);
        bus.Reg2Loc = 1'b0;
        set_ex(5'd2, 3'b001);
        set_ma(5'd12, 3'b101);
        #1;
        checks++;
        if (bus.Db_forwarded !== 64'hCAFE) begin
            errors++;
            $display("[TB] FAIL reg2loc_rd_ma got %h want %h", bus.Db_forwarded, 64'hCAFE);
        end
    endtask

    task automatic test_ma_ignored();
        logic [2:0] ma_ctrls [2];
        ma_ctrls[0] = 3'b100;
        ma_ctrls[1] = 3'b000;
        bus.ID_instruction = id_word(5'd3, 5'd4, 5'd4);
        bus.Reg2Loc = 1'b1;
        bus.Da = 64'hDEAD;
        bus.Db = 64'hF00D;
        for (int i = 0; i < 2; i++) begin
            set_ex(5'd5, 3'b001);
            set_ma(5'd3, ma_ctrls[i]);
            #1;
            checks++;
            if (bus.Da_forwarded !== 64'hDEAD) begin
                errors++;
                $display("[TB] FAIL ma_ignored[%b] got %h want %h", ma_ctrls[i], bus.Da_forwarded, 64'hDEAD);
            end
        end
        // XZR in both stages with writing control must not forward
        bus.ID_instruction = id_word(5'd31, 5'd31, 5'd31);
        set_ex(5'd31, 3'b001);
        set_ma(5'd31, 3'b001);
        #1;
        checks++;
        if (bus.Da_forwarded !== 64'hDEAD) begin
            errors++;
            $display("[TB] FAIL xzr_da got %h want %h", bus.Da_forwarded, 64'hDEAD);
        end
        checks++;
        if (bus.Db_forwarded !== 64'hF00D) begin
            errors++;
            $display("[TB] FAIL xzr_db got %h want %h", bus.Db_forwarded, 64'hF00D);
        end
    endtask

    task automatic test_register();
        @(negedge clk);
        rst_n = 1'b1;
        bus.ID_instruction = id_word(5'd0, 5'd6, 5'd9);
        bus.Reg2Loc = 1'b1;
        bus.Da = 64'hDEAD;
        bus.Db = 64'hF00D;
        set_ex(5'd0, 3'b001);
        set_ma(5'd6, 3'b011);
        @(posedge clk);
        #1;
        checks++;
        if (bus.Da_ex !== 64'hBEEF) begin
            errors++;
            $display("[TB] FAIL reg_da_ex got %h want %h", bus.Da_ex, 64'hBEEF);
        end
        checks++;
        if (bus.Db_ex !== 64'hCAFE) begin
            errors++;
            $display("[TB] FAIL reg_db_ex got %h want %h", bus.Db_ex, 64'hCAFE);
        end
        // New inputs must not reach the register before the next edge
        set_ex(5'd20, 3'b001);
        set_ma(5'd21, 3'b001);
        #2;
        checks++;
        if (bus.Da_ex !== 64'hBEEF) begin
            errors++;
            $display("[TB] FAIL reg_hold got %h want %h", bus.Da_ex, 64'hBEEF);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.Da_ex !== 64'hDEAD) begin
            errors++;
            $display("[TB] FAIL reg_next got %h want %h", bus.Da_ex, 64'hDEAD);
        end
        // Mid-cycle reset clears at once and the pending capture is lost
        set_ex(5'd0, 3'b001);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.Da_ex !== 64'h0 || bus.Db_ex !== 64'h0) begin
            errors++;
            $display("[TB] FAIL midreset got %h/%h want 0/0", bus.Da_ex, bus.Db_ex);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.Da_ex !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_held got %h want %h", bus.Da_ex, 64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.Da_ex !== 64'hBEEF) begin
            errors++;
            $display("[TB] FAIL after_release got %h want %h", bus.Da_ex, 64'hBEEF);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_passthrough();
        test_ex_priority();
        test_ma_past_ex();
        test_reg2loc();
        test_ma_ignored();
        test_register();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
